// File: rtl/seq_det_stream_ctrl.sv
// rtl/seq_det_stream_ctrl.sv - word-to-serial feeder with embedded programmable pattern detector
// Serialises accepted words MSB first, detects a shadowed pattern, counts matches, raises irq.
module seq_det_stream_ctrl #(
  parameter int WORD_W = 8,
  parameter int PAT_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic [CNT_W-1:0]  cfg_thresh,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              ser_bit,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic              irq,
  input  logic              irq_clr,
  output logic              busy
);

  localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WORD_W - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic              overlap_q, overlap_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pulse_q, pulse_d;
  logic              irq_q, irq_d;

  logic              shifting;
  logic              last_bit;
  logic              accept;
  logic              match;
  logic [PAT_W-1:0]  hist_new;
  logic [FILL_W-1:0] fill_new;
  logic [CNT_W-1:0]  count_inc;

  assign shifting = (state_q == S_SHIFT);
  assign last_bit = shifting && (bit_idx_q == '0);
  assign accept   = in_valid && in_ready;

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (accept) state_d = S_SHIFT;
        S_SHIFT: if (last_bit) state_d = accept ? S_SHIFT : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM: outputs; a new word may only enter while idle or on the last bit of the current one
  always_comb begin
    busy     = shifting;
    ser_bit  = 1'b0;
    if (shifting) begin
      ser_bit = word_q[bit_idx_q];
    end
    in_ready = reset_n && !clr && ((state_q == S_IDLE) || last_bit);
  end

  // Detector datapath: history keeps PAT_W-1 past bits, the incoming bit completes the window
  always_comb begin
    hist_new  = {hist_q, ser_bit};
    fill_new  = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    match     = shifting && (hist_new == pat_q) && (fill_new == FILL_FULL);
    count_inc = (count_q == '1) ? count_q : count_q + 1'b1;

    word_d    = word_q;
    pat_d     = pat_q;
    overlap_d = overlap_q;
    bit_idx_d = bit_idx_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    count_d   = count_q;
    pulse_d   = 1'b0;
    irq_d     = irq_q;

    if (accept) begin
      word_d    = in_data;
      pat_d     = cfg_pattern;
      overlap_d = cfg_overlap;
      bit_idx_d = IDX_LAST;
    end else if (shifting && !last_bit) begin
      bit_idx_d = bit_idx_q - 1'b1;
    end

    if (clr) begin
      hist_d  = '0;
      fill_d  = '0;
      count_d = '0;
      irq_d   = 1'b0;
    end else begin
      if (shifting) begin
        hist_d = hist_new[PAT_W-2:0];
        fill_d = (match && !overlap_q) ? '0 : fill_new;
      end
      if (match) begin
        pulse_d = 1'b1;
        count_d = count_inc;
      end
      if (irq_clr) begin
        irq_d = 1'b0;
      end
      // a set in the same cycle as irq_clr must win
      if (match && (cfg_thresh != '0) && (count_inc >= cfg_thresh)) begin
        irq_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q    <= '0;
      pat_q     <= '0;
      overlap_q <= 1'b0;
      bit_idx_q <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      count_q   <= '0;
      pulse_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      word_q    <= word_d;
      pat_q     <= pat_d;
      overlap_q <= overlap_d;
      bit_idx_q <= bit_idx_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
      pulse_q   <= pulse_d;
      irq_q     <= irq_d;
    end
  end

  assign match_pulse = pulse_q;
  assign match_count = count_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_seq_det_stream_ctrl.sv
// tb/tb_seq_det_stream_ctrl.sv - self-checking bench for seq_det_stream_ctrl
// Directed scenarios plus randomized traffic checked against a bit-stream reference model.
module tb_seq_det_stream_ctrl;

  localparam int WORD_W = 8;
  localparam int PAT_W  = 3;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              clr = 1'b0;
  logic [PAT_W-1:0]  cfg_pattern = '0;
  logic              cfg_overlap = 1'b0;
  logic [CNT_W-1:0]  cfg_thresh = '0;
  logic [1:0]        cfg_thresh2 = '0;
  logic              in_valid = 1'b0;
  logic [WORD_W-1:0] in_data = '0;
  logic              irq_clr = 1'b0;

  logic              in_ready, ser_bit, match_pulse, irq, busy;
  logic [CNT_W-1:0]  match_count;
  logic              in_ready2, ser_bit2, match_pulse2, irq2, busy2;
  logic [1:0]        match_count2;

  int errors = 0;
  int checks = 0;

  logic [7:0] acc_w[$];
  logic [2:0] acc_p[$];
  logic       acc_o[$];
  int         got_m[$];
  logic       got_b[$];
  int         bits_seen;

  always #5 clk = ~clk;

  seq_det_stream_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .ser_bit(ser_bit),
    .match_pulse(match_pulse), .match_count(match_count), .irq(irq),
    .irq_clr(irq_clr), .busy(busy)
  );

  seq_det_stream_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh2), .in_valid(in_valid),
    .in_ready(in_ready2), .in_data(in_data), .ser_bit(ser_bit2),
    .match_pulse(match_pulse2), .match_count(match_count2), .irq(irq2),
    .irq_clr(irq_clr), .busy(busy2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    in_valid = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic monitor_cycle();
    @(negedge clk);
    if (match_pulse) got_m.push_back(bits_seen - 1);
    if (busy) begin
      got_b.push_back(ser_bit);
      bits_seen++;
    end
    if (in_valid && in_ready) begin
      acc_w.push_back(in_data);
      acc_p.push_back(cfg_pattern);
      acc_o.push_back(cfg_overlap);
    end
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    step();
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0b expected 0", in_ready);
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy);
    checks++; if (ser_bit !== 1'b0) $display("FAIL reset_ser_bit: got %0b expected 0", ser_bit);
    checks++; if (match_pulse !== 1'b0) $display("FAIL reset_pulse: got %0b expected 0", match_pulse);
    checks++; if (match_count !== '0) $display("FAIL reset_count: got %0d expected 0", match_count);
    checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %0b expected 0", irq);
    if (in_ready !== 1'b0 || busy !== 1'b0 || ser_bit !== 1'b0 || match_pulse !== 1'b0 ||
        match_count !== '0 || irq !== 1'b0) errors++;
    step();
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %0b expected 1", in_ready); end
    step();
    clr = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL clr_in_ready: got %0b expected 0", in_ready); end
    step();
    clr = 1'b0;
  endtask

  task automatic test_pattern_word(input string tag, input logic [7:0] word, input logic [2:0] pat,
                                   input logic ovl, input logic [10:0] exp_mask, input int exp_count,
                                   input logic use_clr);
    logic exp_ser;
    if (use_clr) do_clr();
    in_data = word; cfg_pattern = pat; cfg_overlap = ovl; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_accept: got %0b expected 1", tag, in_ready); end
    step();
    in_valid = 1'b0; cfg_pattern = ~pat; cfg_overlap = ~ovl; in_data = ~word;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      exp_ser = (k <= 8) ? word[8-k] : 1'b0;
      checks++;
      if (busy !== (k <= 8)) begin errors++; $display("FAIL %s_busy k=%0d: got %0b expected %0b", tag, k, busy, k <= 8); end
      checks++;
      if (ser_bit !== exp_ser || ser_bit2 !== exp_ser) begin
        errors++; $display("FAIL %s_ser k=%0d: got %0b/%0b expected %0b", tag, k, ser_bit, ser_bit2, exp_ser);
      end
      checks++;
      if (match_pulse !== exp_mask[k]) begin
        errors++; $display("FAIL %s_pulse k=%0d: got %0b expected %0b", tag, k, match_pulse, exp_mask[k]);
      end
      step();
    end
    checks++;
    if (match_count !== CNT_W'(exp_count)) begin
      errors++; $display("FAIL %s_count: got %0d expected %0d", tag, match_count, exp_count);
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL %s_irq: got %0b expected 0", tag, irq); end
  endtask

  task automatic test_straddle();
    int acc_k;
    logic sent2;
    do_clr();
    cfg_pattern = 3'b101; cfg_overlap = 1'b1; in_data = 8'h02; in_valid = 1'b1;
    @(negedge clk);
    step();
    in_data = 8'h80;
    sent2 = 1'b0; acc_k = -1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        checks++;
        if (in_ready !== (k == 8)) begin errors++; $display("FAIL straddle_ready k=%0d: got %0b expected %0b", k, in_ready, k == 8); end
      end
      checks++;
      if (match_pulse !== (k == 10)) begin errors++; $display("FAIL straddle_pulse k=%0d: got %0b expected %0b", k, match_pulse, k == 10); end
      if (!sent2 && in_valid && in_ready) begin sent2 = 1'b1; acc_k = k; end
      step();
      if (sent2) in_valid = 1'b0;
    end
    checks++;
    if (acc_k != 8) begin errors++; $display("FAIL straddle_accept_cycle: got %0d expected 8", acc_k); end
    checks++;
    if (match_count !== 8'd1) begin errors++; $display("FAIL straddle_count: got %0d expected 1", match_count); end
  endtask

  task automatic test_back_to_back();
    int n_acc;
    logic exp_ready, exp_busy, took;
    do_clr();
    in_valid = 1'b1; in_data = 8'($urandom); cfg_pattern = 3'($urandom);
    n_acc = 0;
    for (int k = 0; k <= 25; k++) begin
      @(negedge clk);
      exp_ready = ((k % 8) == 0) || (k == 25);
      exp_busy  = (k >= 1) && (k <= 24);
      checks++;
      if (in_ready !== exp_ready || in_ready2 !== exp_ready) begin
        errors++; $display("FAIL b2b_ready k=%0d: got %0b/%0b expected %0b", k, in_ready, in_ready2, exp_ready);
      end
      checks++;
      if (busy !== exp_busy || busy2 !== exp_busy) begin
        errors++; $display("FAIL b2b_busy k=%0d: got %0b/%0b expected %0b", k, busy, busy2, exp_busy);
      end
      took = in_valid && in_ready;
      if (took) n_acc++;
      step();
      if (n_acc == 3) in_valid = 1'b0;
      else if (took) in_data = 8'($urandom);
    end
    checks++;
    if (n_acc != 3) begin errors++; $display("FAIL b2b_accepts: got %0d expected 3", n_acc); end
  endtask

  task automatic test_saturate();
    logic       exp_p, exp_i;
    logic [1:0] exp_c;
    do_clr();
    cfg_pattern = 3'b111; cfg_overlap = 1'b1; cfg_thresh = '0; cfg_thresh2 = 2'd2;
    in_data = 8'hFF; in_valid = 1'b1;
    @(negedge clk);
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      exp_p = (k >= 4) && (k <= 9);
      exp_c = (k < 4) ? 2'd0 : ((k - 3) > 3 ? 2'd3 : 2'(k - 3));
      exp_i = (k >= 5);
      checks++;
      if (match_pulse2 !== exp_p) begin errors++; $display("FAIL sat_pulse k=%0d: got %0b expected %0b", k, match_pulse2, exp_p); end
      checks++;
      if (match_count2 !== exp_c) begin errors++; $display("FAIL sat_count k=%0d: got %0d expected %0d", k, match_count2, exp_c); end
      checks++;
      if (irq2 !== exp_i) begin errors++; $display("FAIL sat_irq k=%0d: got %0b expected %0b", k, irq2, exp_i); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL thresh0_irq k=%0d: got %0b expected 0", k, irq); end
      step();
    end
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (irq2 !== 1'b0) begin errors++; $display("FAIL irq_clr: got %0b expected 0", irq2); end
    checks++;
    if (match_count2 !== 2'd3) begin errors++; $display("FAIL sat_hold: got %0d expected 3", match_count2); end
    checks++;
    if (match_count !== 8'd6) begin errors++; $display("FAIL wide_count: got %0d expected 6", match_count); end
    step();
    cfg_thresh2 = '0;
  endtask

  task automatic test_reset_midword();
    do_clr();
    cfg_pattern = 3'b101; cfg_overlap = 1'b1; in_data = 8'hA8; in_valid = 1'b1;
    @(negedge clk);
    step();
    in_valid = 1'b0;
    for (int k = 1; k < 4; k++) step();
    checks++;
    if (match_pulse !== 1'b1) begin errors++; $display("FAIL mid_pre_pulse: got %0b expected 1", match_pulse); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || ser_bit !== 1'b0 || match_pulse !== 1'b0 || match_count !== '0 ||
        irq !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got busy=%0b ser=%0b pulse=%0b count=%0d irq=%0b ready=%0b expected all 0",
               busy, ser_bit, match_pulse, match_count, irq, in_ready);
    end
    step();
    reset_n = 1'b1;
    test_pattern_word("after_reset", 8'hA8, 3'b101, 1'b1, 11'h050, 2, 1'b0);
  endtask

  task automatic test_random();
    logic       bits[$];
    logic [2:0] pb[$];
    logic       ob[$];
    int         exp_m[$];
    int         base, n;
    logic [7:0] w;
    logic [CNT_W-1:0] exp_cnt;
    do_clr();
    acc_w.delete(); acc_p.delete(); acc_o.delete(); got_m.delete(); got_b.delete();
    bits_seen = 0;
    cfg_thresh = CNT_W'($urandom_range(1, 12));
    for (int c = 0; c < 300; c++) begin
      in_valid = (($urandom % 4) != 0);
      in_data = 8'($urandom);
      cfg_pattern = 3'($urandom);
      cfg_overlap = 1'($urandom);
      monitor_cycle();
      step();
    end
    in_valid = 1'b0;
    for (int d = 0; d < 12; d++) begin
      monitor_cycle();
      step();
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rand_drain: busy still %0b after bound", busy); end

    for (int i = 0; i < acc_w.size(); i++) begin
      w = acc_w[i];
      for (int b = 7; b >= 0; b--) begin
        bits.push_back(w[b]); pb.push_back(acc_p[i]); ob.push_back(acc_o[i]);
      end
    end
    base = 0;
    for (int i = 0; i < bits.size(); i++) begin
      if ((i - base + 1) >= PAT_W && {bits[i-2], bits[i-1], bits[i]} == pb[i]) begin
        exp_m.push_back(i);
        if (!ob[i]) base = i + 1;
      end
    end

    checks++;
    if (got_b.size() != bits.size()) begin errors++; $display("FAIL rand_bits_len: got %0d expected %0d", got_b.size(), bits.size()); end
    for (int i = 0; i < bits.size() && i < got_b.size(); i++) begin
      checks++;
      if (got_b[i] !== bits[i]) begin errors++; $display("FAIL rand_bit[%0d]: got %0b expected %0b", i, got_b[i], bits[i]); end
    end
    checks++;
    if (got_m.size() != exp_m.size()) begin errors++; $display("FAIL rand_matches: got %0d expected %0d", got_m.size(), exp_m.size()); end
    for (int i = 0; i < exp_m.size() && i < got_m.size(); i++) begin
      checks++;
      if (got_m[i] != exp_m[i]) begin errors++; $display("FAIL rand_match_pos[%0d]: got %0d expected %0d", i, got_m[i], exp_m[i]); end
    end
    n = exp_m.size();
    exp_cnt = (n > 255) ? 8'd255 : CNT_W'(n);
    checks++;
    if (match_count !== exp_cnt) begin errors++; $display("FAIL rand_count: got %0d expected %0d", match_count, exp_cnt); end
    checks++;
    if (irq !== (n >= int'(cfg_thresh))) begin
      errors++; $display("FAIL rand_irq: got %0b expected %0b", irq, n >= int'(cfg_thresh));
    end
  endtask

  initial begin
    test_reset();
    test_pattern_word("overlap", 8'hA8, 3'b101, 1'b1, 11'h050, 2, 1'b1);
    test_pattern_word("non_overlap", 8'hA8, 3'b101, 1'b0, 11'h010, 1, 1'b1);
    test_straddle();
    test_back_to_back();
    test_saturate();
    test_reset_midword();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
